// File: rtl/irq_pkg.sv
// Shared constants, FSM state type and grant-clear helper for the 8-to-3 IRQ encoder.
package irq_pkg;

   localparam int unsigned N = 8;
   localparam int unsigned W = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   function automatic logic [N-1:0] clr_onehot(input logic [W-1:0] code);
      logic [N-1:0] m;
      m       = '0;
      m[code] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/irq_encoder_8_3_if.sv
// Request/grant bundle between event sources, the encoder and its consumer.
interface irq_encoder_8_3_if;
   import irq_pkg::*;

   logic [N-1:0] req;
   logic [N-1:0] mask;
   logic         ack;
   logic [W-1:0] code;
   logic         valid;
   logic [N-1:0] pending;
   logic         overrun;

   modport master (
      output req, mask, ack,
      input  code, valid, pending, overrun
   );

   modport slave (
      input  req, mask, ack,
      output code, valid, pending, overrun
   );
endinterface

// File: rtl/irq_encoder_8_3_prio.sv
// Combinational 8-to-3 priority encoder; direction selected by i_high_first.
module prio_enc_8_3
   import irq_pkg::*;
(
   input  logic [N-1:0] i_vector,
   input  logic         i_high_first,
   output logic [W-1:0] o_idx,
   output logic         o_any
);

   always_comb begin
      o_idx = '0;
      o_any = |i_vector;
      // Scan so the winning bit is the last one assigned.
      if (i_high_first) begin
         for (int unsigned k = 0; k < N; k++) begin
            if (i_vector[k]) o_idx = W'(k);
         end
      end else begin
         for (int unsigned k = 0; k < N; k++) begin
            if (i_vector[N-1-k]) o_idx = W'(N-1-k);
         end
      end
   end

endmodule

// File: rtl/irq_encoder_8_3.sv
// Sticky edge-captured request register with prioritised valid/ack grant of one line at a time.
module irq_encoder_8_3
   import irq_pkg::*;
#(
   parameter bit HIGH_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   irq_encoder_8_3_if.slave  bus
);

   logic [N-1:0] r_req_q;
   logic [N-1:0] r_pending;
   logic [W-1:0] r_code;
   logic         r_overrun;
   state_t       r_state;

   state_t       w_state_nxt;
   logic         w_load;
   logic         w_valid;
   logic [N-1:0] w_edge;
   logic [N-1:0] w_clr;
   logic [W-1:0] w_idx;
   logic         w_any;

   assign w_valid = (r_state == GRANT);
   assign w_edge  = bus.req & ~r_req_q;
   assign w_clr   = (w_valid && bus.ack) ? clr_onehot(r_code) : '0;

   prio_enc_8_3 u_prio (
      .i_vector     (r_pending & bus.mask),
      .i_high_first (HIGH_FIRST),
      .o_idx        (w_idx),
      .o_any        (w_any)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_load      = 1'b1;
               w_state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (bus.ack) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Edge OR-in after clear: a new event on the line being acked stays pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_req_q   <= '0;
         r_pending <= '0;
         r_code    <= '0;
         r_overrun <= 1'b0;
         r_state   <= IDLE;
      end else begin
         r_req_q   <= bus.req;
         r_pending <= (r_pending & ~w_clr) | w_edge;
         r_overrun <= r_overrun | (|(w_edge & r_pending & ~w_clr));
         r_state   <= w_state_nxt;
         if (w_load) r_code <= w_idx;
      end
   end

   assign bus.code    = r_code;
   assign bus.valid   = w_valid;
   assign bus.pending = r_pending;
   assign bus.overrun = r_overrun;

endmodule

// File: tb/tb_irq_encoder_8_3.sv
// Directed-vector bench for irq_encoder_8_3, both priority directions.
module tb_irq_encoder_8_3;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   irq_encoder_8_3_if ifh ();
   irq_encoder_8_3_if ifl ();

   irq_encoder_8_3 #(.HIGH_FIRST(1'b1)) dut_h (
      .clk (clk),
      .rst (rst),
      .bus (ifh.slave)
   );

   irq_encoder_8_3 #(.HIGH_FIRST(1'b0)) dut_l (
      .clk (clk),
      .rst (rst),
      .bus (ifl.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_h(input string tag, input logic v, input logic [2:0] c, input logic [7:0] p);
      chk({tag, ".valid"},   {7'd0, ifh.valid}, {7'd0, v});
      chk({tag, ".code"},    {5'd0, ifh.code},  {5'd0, c});
      chk({tag, ".pending"}, ifh.pending,       p);
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      rst      = 1'b1;
      ifh.req  = '0; ifh.mask = 8'hFF; ifh.ack = 1'b0;
      ifl.req  = '0; ifl.mask = 8'hFF; ifl.ack = 1'b0;
      tick(); tick();
      rst = 1'b0;

      // reset state
      chk_h("rst", 1'b0, 3'd0, 8'h00);
      chk("rst.overrun", {7'd0, ifh.overrun}, 8'h00);

      // single event on line 5: pending at E0, valid after E1
      ifh.req = 8'h20; tick();
      chk_h("single.e0", 1'b0, 3'd0, 8'h20);
      ifh.req = 8'h00; tick();
      chk_h("single.e1", 1'b1, 3'd5, 8'h20);
      ifh.ack = 1'b1; tick();
      ifh.ack = 1'b0;
      chk_h("single.ack", 1'b0, 3'd5, 8'h00);

      // simultaneous 3 and 6, high first
      ifh.req = 8'h48; tick();
      ifh.req = 8'h00; tick();
      chk_h("simH.g1", 1'b1, 3'd6, 8'h48);
      ifh.ack = 1'b1; tick();
      ifh.ack = 1'b0;
      chk_h("simH.idle", 1'b0, 3'd6, 8'h08);
      tick();
      chk_h("simH.g2", 1'b1, 3'd3, 8'h08);
      ifh.ack = 1'b1; tick();
      ifh.ack = 1'b0;
      chk_h("simH.done", 1'b0, 3'd3, 8'h00);

      // simultaneous 3 and 6, low first
      ifl.req = 8'h48; tick();
      ifl.req = 8'h00; tick();
      chk("simL.g1.valid", {7'd0, ifl.valid}, 8'h01);
      chk("simL.g1.code",  {5'd0, ifl.code},  8'h03);
      ifl.ack = 1'b1; tick();
      ifl.ack = 1'b0;
      chk("simL.idle.valid", {7'd0, ifl.valid}, 8'h00);
      chk("simL.idle.pending", ifl.pending, 8'h40);
      tick();
      chk("simL.g2.code", {5'd0, ifl.code}, 8'h06);
      ifl.ack = 1'b1; tick();
      ifl.ack = 1'b0;
      chk("simL.done.pending", ifl.pending, 8'h00);

      // grant held against higher-priority event and mask removal
      ifh.req = 8'h04; tick();
      ifh.req = 8'h00; tick();
      chk_h("hold.g", 1'b1, 3'd2, 8'h04);
      ifh.req = 8'h80; ifh.mask = 8'h00; tick();
      ifh.req = 8'h00;
      chk_h("hold.new", 1'b1, 3'd2, 8'h84);
      tick();
      chk_h("hold.still", 1'b1, 3'd2, 8'h84);
      ifh.mask = 8'hFF; ifh.ack = 1'b1; tick();
      ifh.ack = 1'b0;
      chk_h("hold.ack", 1'b0, 3'd2, 8'h80);
      tick();
      chk_h("hold.next", 1'b1, 3'd7, 8'h80);
      ifh.ack = 1'b1; tick();
      ifh.ack = 1'b0;

      // masked line stays pending without grant
      ifh.mask = 8'h00; ifh.req = 8'h02; tick();
      ifh.req = 8'h00; tick(); tick();
      chk_h("mask.held", 1'b0, 3'd7, 8'h02);
      ifh.mask = 8'h02; tick();
      chk_h("mask.open", 1'b1, 3'd1, 8'h02);
      ifh.ack = 1'b1; tick();
      ifh.ack = 1'b0; ifh.mask = 8'hFF;

      // set wins over clear on the acked line
      ifh.req = 8'h10; tick();
      ifh.req = 8'h00; tick();
      chk_h("setwin.g", 1'b1, 3'd4, 8'h10);
      ifh.req = 8'h10; ifh.ack = 1'b1; tick();
      ifh.req = 8'h00; ifh.ack = 1'b0;
      chk_h("setwin.ack", 1'b0, 3'd4, 8'h10);
      chk("setwin.overrun", {7'd0, ifh.overrun}, 8'h00);
      tick();
      chk_h("setwin.regrant", 1'b1, 3'd4, 8'h10);

      // second event while pending and not acked -> sticky overrun
      ifh.req = 8'h10; tick();
      ifh.req = 8'h00;
      chk("ovr.set", {7'd0, ifh.overrun}, 8'h01);
      ifh.ack = 1'b1; tick();
      ifh.ack = 1'b0; tick();
      chk("ovr.sticky", {7'd0, ifh.overrun}, 8'h01);
      ifh.req = 8'h01; tick();
      ifh.req = 8'h00; tick();
      chk_h("midgrant.g", 1'b1, 3'd0, 8'h01);
      ifh.req = 8'h08; tick();
      ifh.req = 8'h00; tick();

      // reset mid-grant
      chk_h("rst2.pre", 1'b1, 3'd0, 8'h09);
      rst = 1'b1; tick();
      rst = 1'b0;
      chk_h("rst2", 1'b0, 3'd0, 8'h00);
      chk("rst2.overrun", {7'd0, ifh.overrun}, 8'h00);

      // stray ack in IDLE has no effect
      ifh.ack = 1'b1; tick(); tick();
      chk_h("stray", 1'b0, 3'd0, 8'h00);
      ifh.req = 8'h40; tick();
      ifh.req = 8'h00;
      chk_h("stray.ev", 1'b0, 3'd0, 8'h40);
      ifh.ack = 1'b0; tick();
      chk_h("stray.g", 1'b1, 3'd6, 8'h40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
